// File: rtl/pipe_col_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_col_pkg
// Description : Shared defaults, the occupancy-width helper and the occupancy
//               count type for the pipeline result collector.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_col_pkg;

    localparam int N_DEF     = 10;
    localparam int LAT_DEF   = 3;
    localparam int DEPTH_DEF = 4;

    // Bits needed to count 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int OCC_W_DEF = $clog2(DEPTH_DEF + 1);

    typedef logic [OCC_W_DEF-1:0] occ_t;

endpackage
`default_nettype wire

// File: rtl/pipe_col_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_col_fifo
// Description : Synchronous FIFO with push/pop/full/empty/count. Pointers wrap
//               by compare-and-clear, so DEPTH need not be a power of two.
//               A push on a full FIFO is accepted only when a pop happens on
//               the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_col_fifo
    import pipe_col_pkg::*;
#(
    parameter int WIDTH = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CNT_W = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    // Storage, pointers and count; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= w_wr_next;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : pipe_result_collector
// Description : Collects results of a fixed-latency, stall-free arithmetic
//               pipeline. A valid shift register aligned to the pipeline
//               latency marks which pipe_f samples are real; those are pushed
//               into a FIFO drained over valid/ready. issue_ok gives upstream
//               a credit so issues cannot outrun FIFO space.
//               Optional macro PIPE_COL_STATS_EN adds res_count and max_occ.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_result_collector
    import pipe_col_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int OCC_W = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ok,
    input  logic [N-1:0]     pipe_f,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy,
    output logic             overflow
`ifdef PIPE_COL_STATS_EN
    ,
    output logic [15:0]      res_count,
    output logic [OCC_W-1:0] max_occ
`endif
);

    localparam int INF_W = $clog2(LAT + 1);
    localparam int SUM_W = occ_w(DEPTH + LAT);

    logic [LAT-1:0]   r_vsr;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [INF_W-1:0] w_inflight;
    logic [SUM_W-1:0] w_committed;

    assign w_push    = r_vsr[LAT-1];
    assign w_pop     = out_valid & out_ready;
    assign out_valid = ~w_empty;
    assign overflow  = r_overflow;

    pipe_col_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (pipe_f),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    generate
        if (LAT > 1) begin : g_vsr_multi
            // Shift issue marks along so the top bit lines up with pipe_f.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= {r_vsr[LAT-2:0], issue_valid};
                end
            end
        end else begin : g_vsr_single
            // Single-cycle pipeline: the mark only needs one stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= issue_valid;
                end
            end
        end
    endgenerate

    // Credit: queued plus in-flight results must leave room for one more.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + INF_W'(r_vsr[i]);
        end
        w_committed = SUM_W'(occupancy) + SUM_W'(w_inflight);
        issue_ok    = (w_committed < SUM_W'(DEPTH));
    end

    // Sticky flag for a result lost to a full FIFO with no same-edge pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef PIPE_COL_STATS_EN
    // Count delivered results and track the occupancy high-water mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count <= '0;
            max_occ   <= '0;
        end else begin
            if (w_pop) begin
                res_count <= res_count + 16'd1;
            end
            if (occupancy > max_occ) begin
                max_occ <= occupancy;
            end
        end
    end
`endif

endmodule
`default_nettype wire
